// File: rtl/riscv_alu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_alu_pkg
// Shared decode constants for the RV32I execute-stage ALU: funct3 operation
// codes, bus widths and the funct7 bit that selects SUB / SRA.
// Build option: ALU_FLAGS_EN (see riscv_alu.sv) enables the status flags.
// -----------------------------------------------------------------------------
package riscv_alu_pkg;

    localparam int FUNCT3_W    = 3;
    localparam int FUNCT7_W    = 7;
    // funct7 bit that turns ADD into SUB and SRL into SRA
    localparam int F7_ALT_BIT  = 5;

    typedef enum logic [FUNCT3_W-1:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } f3_e;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational log2(SIZE)-stage barrel shifter.
// Ports:
//   data   in  SIZE          value to shift
//   shamt  in  $clog2(SIZE)  shift amount
//   left   in  1             1 = shift left, 0 = shift right
//   arith  in  1             right shifts only: 1 = sign fill, 0 = zero fill
//   result out SIZE          shifted value
// Left shifts reuse the right-shift datapath by bit-reversing the operand on
// the way in and the result on the way out.
// -----------------------------------------------------------------------------
module alu_shifter #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0]         data,
    input  logic [$clog2(SIZE)-1:0] shamt,
    input  logic                    left,
    input  logic                    arith,
    output logic [SIZE-1:0]         result
);

    localparam int SHW = $clog2(SIZE);

    function automatic logic [SIZE-1:0] bit_reverse(input logic [SIZE-1:0] v);
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) begin
            r[i] = v[SIZE-1-i];
        end
        return r;
    endfunction

    logic [SIZE-1:0]   stage;
    logic [2*SIZE-1:0] ext;
    logic              fill;

    always_comb begin
        fill  = arith & ~left & data[SIZE-1];
        stage = left ? bit_reverse(data) : data;
        ext   = '0;
        for (int s = 0; s < SHW; s++) begin
            if (shamt[s]) begin
                // fill bits sit above the operand and slide in from the top
                ext   = {{SIZE{fill}}, stage} >> (1 << s);
                stage = ext[SIZE-1:0];
            end
        end
        result = left ? bit_reverse(stage) : stage;
    end

endmodule

// File: rtl/riscv_alu.sv
// -----------------------------------------------------------------------------
// riscv_alu
// RV32I integer ALU (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) with a
// single registered output stage (latency 1).
// Build option: define ALU_FLAGS_EN to compute and register zero/neg/cry/ovf;
// without it the flag ports are tied to 0 and no flag logic exists.
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset, clears result and flags
//   f3_i    in   3      funct3 operation select
//   f7_i    in   7      funct7; only bit 5 (SUB / SRA) is used
//   op1_i   in   SIZE   operand 1 (rs1)
//   op2_i   in   SIZE   operand 2 (rs2 or immediate)
//   res_o   out  SIZE   registered result
//   zero_o  out  1      result == 0
//   neg_o   out  1      result MSB
//   cry_o   out  1      ADD carry out / SUB borrow, else 0
//   ovf_o   out  1      ADD/SUB signed overflow, else 0
// -----------------------------------------------------------------------------
module riscv_alu
    import riscv_alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FUNCT3_W-1:0] f3_i,
    input  logic [FUNCT7_W-1:0] f7_i,
    input  logic [SIZE-1:0]     op1_i,
    input  logic [SIZE-1:0]     op2_i,
    output logic [SIZE-1:0]     res_o,
    output logic                zero_o,
    output logic                neg_o,
    output logic                cry_o,
    output logic                ovf_o
);

    localparam int SHW = $clog2(SIZE);

    f3_e             op;
    logic            alt;
    logic            use_sub;
    logic [SIZE-1:0] op2_x;
    logic [SIZE:0]   sum_ext;
    logic [SIZE-1:0] sum;
    logic            carry;
    logic            ovf;
    logic            lt_s;
    logic            lt_u;
    logic [SIZE-1:0] shift_res;
    logic [SIZE-1:0] res_d;
    logic            unused_f7;

    assign op        = f3_e'(f3_i);
    assign alt       = f7_i[F7_ALT_BIT];
    assign unused_f7 = ^{f7_i[FUNCT7_W-1:F7_ALT_BIT+1], f7_i[F7_ALT_BIT-1:0]};

    // One adder serves ADD, SUB and both compares; compares always subtract.
    assign use_sub = (op == F3_ADD_SUB) ? alt : 1'b1;
    assign op2_x   = op2_i ^ {SIZE{use_sub}};
    assign sum_ext = {1'b0, op1_i} + {1'b0, op2_x} + {{SIZE{1'b0}}, use_sub};
    assign sum     = sum_ext[SIZE-1:0];
    assign carry   = sum_ext[SIZE];

    // Overflow of op1 + op2_x: same operand signs, result sign differs.
    // This covers both the ADD and SUB definitions.
    assign ovf  = (op1_i[SIZE-1] == op2_x[SIZE-1]) && (sum[SIZE-1] != op1_i[SIZE-1]);
    assign lt_s = sum[SIZE-1] ^ ovf;
    // For subtraction carry out is the inverted borrow.
    assign lt_u = ~carry;

    alu_shifter #(
        .SIZE(SIZE)
    ) u_shifter (
        .data   (op1_i),
        .shamt  (op2_i[SHW-1:0]),
        .left   (op == F3_SLL),
        .arith  (alt),
        .result (shift_res)
    );

    always_comb begin
        res_d = '0;
        case (op)
            F3_ADD_SUB: res_d = sum;
            F3_SLL:     res_d = shift_res;
            F3_SLT:     res_d = {{(SIZE-1){1'b0}}, lt_s};
            F3_SLTU:    res_d = {{(SIZE-1){1'b0}}, lt_u};
            F3_XOR:     res_d = op1_i ^ op2_i;
            F3_SRL_SRA: res_d = shift_res;
            F3_OR:      res_d = op1_i | op2_i;
            F3_AND:     res_d = op1_i & op2_i;
            default:    res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_o <= '0;
        end else begin
            res_o <= res_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic is_addsub;
    assign is_addsub = (op == F3_ADD_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_o <= 1'b0;
            neg_o  <= 1'b0;
            cry_o  <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            zero_o <= (res_d == '0);
            neg_o  <= res_d[SIZE-1];
            // SUB reports borrow, ADD reports carry
            cry_o  <= is_addsub & (alt ? ~carry : carry);
            ovf_o  <= is_addsub & ovf;
        end
    end
`else
    assign zero_o = 1'b0;
    assign neg_o  = 1'b0;
    assign cry_o  = 1'b0;
    assign ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu
// Self-checking bench for riscv_alu at SIZE=4. Expected values come from an
// integer-arithmetic reference model. Flag expectations follow ALU_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_riscv_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [W-1:0] op1, op2;
    logic [W-1:0] res;
    logic         zero, neg, cry, ovf;

    int n_vec = 0;
    int n_bad = 0;

    logic [W+3:0] exp_q[$];

    riscv_alu #(.SIZE(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .f3_i   (f3),
        .f7_i   (f7),
        .op1_i  (op1),
        .op2_i  (op2),
        .res_o  (res),
        .zero_o (zero),
        .neg_o  (neg),
        .cry_o  (cry),
        .ovf_o  (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {result, zero, neg, cry, ovf}; flags are 0 when the feature is off.
    function automatic logic [W+3:0] model(input logic [2:0] mf3, input logic [6:0] mf7,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, r, sh, full;
        logic c, v;
        logic [W-1:0] rr;
        ua = int'(a);
        ub = int'(b);
        full = 1 << W;
        sa = (ua >= full / 2) ? ua - full : ua;
        sb = (ub >= full / 2) ? ub - full : ub;
        sh = ub % W;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (mf3)
            3'd0: begin
                if (mf7[5]) begin
                    r = ua - ub;
                    c = (ua < ub);
                    v = ((sa - sb) > full / 2 - 1) || ((sa - sb) < -(full / 2));
                end else begin
                    r = ua + ub;
                    c = (r >= full);
                    v = ((sa + sb) > full / 2 - 1) || ((sa + sb) < -(full / 2));
                end
            end
            3'd1: r = ua << sh;
            3'd2: r = (sa < sb) ? 1 : 0;
            3'd3: r = (ua < ub) ? 1 : 0;
            3'd4: r = ua ^ ub;
            3'd5: r = mf7[5] ? (sa >>> sh) : (ua >> sh);
            3'd6: r = ua | ub;
            default: r = ua & ub;
        endcase
        rr = r[W-1:0];
`ifdef ALU_FLAGS_EN
        return {rr, (rr == '0), rr[W-1], c, v};
`else
        return {rr, 4'b0000};
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [2:0] df3, input logic [6:0] df7,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        f3  = df3;
        f7  = df7;
        op1 = a;
        op2 = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W+3:0] exp;
        rst = 1'b1;
        drive(3'b000, 7'b0000000, 4'd7, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold: got %b required %b", {res, zero, neg, cry, ovf}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        exp = model(3'b000, 7'b0000000, 4'd7, 4'd1);
        @(posedge clk);
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== exp) begin
            n_bad++;
            $display("FAIL reset_release_add: got %b required %b", {res, zero, neg, cry, ovf}, exp);
        end
    endtask

    task automatic test_directed();
        // {f3, f7[5], op1, op2} and expected result from the worked examples
        logic [11:0] vec [12];
        logic [3:0]  want [12];
        logic [W+3:0] exp;
        vec[0]  = {3'b000, 1'b1, 4'b1111, 4'b1000}; want[0]  = 4'b0111;
        vec[1]  = {3'b000, 1'b1, 4'b1000, 4'b1111}; want[1]  = 4'b1001;
        vec[2]  = {3'b000, 1'b1, 4'b0111, 4'b1101}; want[2]  = 4'b1010;
        vec[3]  = {3'b000, 1'b1, 4'b1101, 4'b0110}; want[3]  = 4'b0111;
        vec[4]  = {3'b000, 1'b1, 4'b1011, 4'b1011}; want[4]  = 4'b0000;
        vec[5]  = {3'b000, 1'b1, 4'b0100, 4'b0100}; want[5]  = 4'b0000;
        vec[6]  = {3'b010, 1'b0, 4'b1110, 4'b0001}; want[6]  = 4'b0001;
        vec[7]  = {3'b011, 1'b0, 4'b1110, 4'b0001}; want[7]  = 4'b0000;
        vec[8]  = {3'b101, 1'b1, 4'b1000, 4'b0001}; want[8]  = 4'b1100;
        vec[9]  = {3'b101, 1'b0, 4'b1000, 4'b0001}; want[9]  = 4'b0100;
        vec[10] = {3'b001, 1'b0, 4'b0011, 4'b0110}; want[10] = 4'b1100;
        vec[11] = {3'b000, 1'b0, 4'b1111, 4'b0001}; want[11] = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vec[i][11:9], {1'b0, vec[i][8], 5'b00000}, vec[i][7:4], vec[i][3:0]);
            exp = model(f3, f7, op1, op2);
            @(posedge clk);
            #1;
            n_vec++;
            if (res !== want[i]) begin
                n_bad++;
                $display("FAIL directed_res[%0d]: got %b required %b", i, res, want[i]);
            end
            n_vec++;
            if ({res, zero, neg, cry, ovf} !== exp) begin
                n_bad++;
                $display("FAIL directed_flags[%0d]: got %b required %b", i, {res, zero, neg, cry, ovf}, exp);
            end
        end
    endtask

    // Every f3 with both f7[5] values and all other f7 bits set, on boundary operands.
    task automatic test_back_to_back();
        logic [W-1:0] edge_v [4];
        logic [W+3:0] exp;
        edge_v[0] = 4'b0000; edge_v[1] = 4'b1111; edge_v[2] = 4'b1000; edge_v[3] = 4'b0111;
        for (int op = 0; op < 8; op++) begin
            for (int alt = 0; alt < 2; alt++) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    drive(3'(op), alt[0] ? 7'b1111111 : 7'b1011111, edge_v[k], edge_v[(k + 1) % 4]);
                    exp_q.push_back(model(f3, f7, op1, op2));
                    @(posedge clk);
                    #1;
                    exp = exp_q.pop_front();
                    n_vec++;
                    if ({res, zero, neg, cry, ovf} !== exp) begin
                        n_bad++;
                        $display("FAIL b2b f3=%0d alt=%0d k=%0d: got %b required %b", op, alt, k,
                                 {res, zero, neg, cry, ovf}, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W+3:0] exp;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                  W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            exp_q.push_back(model(f3, f7, op1, op2));
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            n_vec++;
            if ({res, zero, neg, cry, ovf} !== exp) begin
                n_bad++;
                $display("FAIL random[%0d] f3=%b f7=%b op1=%b op2=%b: got %b required %b",
                         i, f3, f7, op1, op2, {res, zero, neg, cry, ovf}, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W+3:0] exp;
        // establish a non-zero registered result first
        @(negedge clk);
        drive(3'b000, 7'b0000000, 4'b0011, 4'b0100);
        @(posedge clk);
        #1;
        n_vec++;
        if (res !== 4'b0111) begin
            n_bad++;
            $display("FAIL midrst_setup: got %b required %b", res, 4'b0111);
        end
        // SUB pending, reset asserted between edges
        @(negedge clk);
        drive(3'b000, 7'b0100000, 4'b1011, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_async: got %b required %b", {res, zero, neg, cry, ovf}, 8'h00);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_held: got %b required %b", {res, zero, neg, cry, ovf}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_no_stale: got %b required %b", {res, zero, neg, cry, ovf}, 8'h00);
        end
        exp = model(f3, f7, op1, op2);
        @(posedge clk);
        #1;
        n_vec++;
        if ({res, zero, neg, cry, ovf} !== exp) begin
            n_bad++;
            $display("FAIL midrst_resume: got %b required %b", {res, zero, neg, cry, ovf}, exp);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
